// File: rtl/data_mem_controller.sv
// Data-memory access controller: turns pipeline load/store requests into level
// handshakes with data memory, with alignment checks, a handshake timeout and load extension.
module data_mem_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [63:0] cpu_address,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    input  logic [63:0] cpu_write_data,
    output logic [63:0] cpu_read_data,
    output logic        cpu_stall,
    output logic        cpu_error,
    output logic        read_request,
    output logic        write_request,
    input  logic        read_ready,
    input  logic        write_ready,
    input  logic        write_finished,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_block_size,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT_READY,
        WR_WAIT_DONE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               read_request_q, read_request_d;
    logic               write_request_q, write_request_d;
    logic               cpu_error_q, cpu_error_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [63:0]        cpu_read_data_q, cpu_read_data_d;
    logic [63:0]        mem_address_q, mem_address_d;
    logic [1:0]         mem_block_size_q, mem_block_size_d;
    logic [63:0]        mem_write_data_q, mem_write_data_d;
    logic               mem_signed_q, mem_signed_d;

    logic               req_present;
    logic               misaligned;
    logic               timeout;
    logic [CNT_W-1:0]   cnt_next;

    // Right-aligned load extension by access size
    function automatic logic [63:0] extend_load(input logic [63:0] d,
                                                input logic [1:0]  size,
                                                input logic        sgn);
        case (size)
            2'b00:   return {{56{sgn & d[7]}},  d[7:0]};
            2'b01:   return {{48{sgn & d[15]}}, d[15:0]};
            2'b10:   return {{32{sgn & d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

    always_comb begin
        case (cpu_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = cpu_address[0];
            2'b10:   misaligned = |cpu_address[1:0];
            default: misaligned = |cpu_address[2:0];
        endcase
    end

    assign req_present = cpu_mem_read | cpu_mem_write;
    assign timeout     = (wait_cnt_q == CNT_LAST);
    // Saturate so a late write_ready cannot wrap the shared write budget
    assign cnt_next    = timeout ? wait_cnt_q : wait_cnt_q + CNT_W'(1);

    always_comb begin
        state_d          = state_q;
        err_d            = err_q;
        wait_cnt_d       = wait_cnt_q;
        cpu_read_data_d  = cpu_read_data_q;
        mem_address_d    = mem_address_q;
        mem_block_size_d = mem_block_size_q;
        mem_write_data_d = mem_write_data_q;
        mem_signed_d     = mem_signed_q;

        case (state_q)
            IDLE: begin
                if (req_present) begin
                    wait_cnt_d = '0;
                    if ((cpu_mem_read & cpu_mem_write) | misaligned) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d            = 1'b0;
                        mem_address_d    = cpu_address;
                        mem_block_size_d = cpu_size;
                        mem_write_data_d = cpu_write_data;
                        mem_signed_d     = cpu_signed;
                        state_d          = cpu_mem_read ? RD_WAIT : WR_WAIT_READY;
                    end
                end
            end
            RD_WAIT: begin
                wait_cnt_d = cnt_next;
                if (read_ready) begin
                    cpu_read_data_d = extend_load(mem_read_data, mem_block_size_q, mem_signed_q);
                    state_d         = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WR_WAIT_READY: begin
                wait_cnt_d = cnt_next;
                if (write_ready) begin
                    state_d = WR_WAIT_DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WR_WAIT_DONE: begin
                wait_cnt_d = cnt_next;
                if (write_finished) begin
                    state_d = DONE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        read_request_d  = (state_d == RD_WAIT);
        write_request_d = (state_d == WR_WAIT_READY);
        cpu_error_d     = (state_d == DONE) & err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            read_request_q   <= 1'b0;
            write_request_q  <= 1'b0;
            cpu_error_q      <= 1'b0;
            err_q            <= 1'b0;
            wait_cnt_q       <= '0;
            cpu_read_data_q  <= '0;
            mem_address_q    <= '0;
            mem_block_size_q <= '0;
            mem_write_data_q <= '0;
            mem_signed_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            read_request_q   <= read_request_d;
            write_request_q  <= write_request_d;
            cpu_error_q      <= cpu_error_d;
            err_q            <= err_d;
            wait_cnt_q       <= wait_cnt_d;
            cpu_read_data_q  <= cpu_read_data_d;
            mem_address_q    <= mem_address_d;
            mem_block_size_q <= mem_block_size_d;
            mem_write_data_q <= mem_write_data_d;
            mem_signed_q     <= mem_signed_d;
        end
    end

    // Stall holds the pipeline from request acceptance until the DONE cycle
    assign cpu_stall      = (state_q == IDLE) ? req_present : (state_q != DONE);
    assign read_request   = read_request_q;
    assign write_request  = write_request_q;
    assign cpu_error      = cpu_error_q;
    assign cpu_read_data  = cpu_read_data_q;
    assign mem_address    = mem_address_q;
    assign mem_block_size = mem_block_size_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: directed vector table, reset
// sequences and randomized transactions against a duration-based reference model.
module tb_data_mem_controller;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_read, cpu_mem_write, cpu_signed;
    logic [63:0] cpu_address, cpu_write_data, cpu_read_data;
    logic [1:0]  cpu_size;
    logic        cpu_stall, cpu_error, read_request, write_request;
    logic        read_ready, write_ready, write_finished;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic [1:0]  mem_block_size;

    always #5 clk = ~clk;

    data_mem_controller #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_address(cpu_address), .cpu_size(cpu_size), .cpu_signed(cpu_signed),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
        .cpu_stall(cpu_stall), .cpu_error(cpu_error),
        .read_request(read_request), .write_request(write_request),
        .read_ready(read_ready), .write_ready(write_ready), .write_finished(write_finished),
        .mem_address(mem_address), .mem_block_size(mem_block_size),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [63:0] addr;
        logic [1:0]  size;
        bit          sgn;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          k1;      // wait-state index at which read_ready / write_ready arrives
        int          k2;      // WR_WAIT_DONE index at which write_finished arrives
        bit          exp_err;
        logic [63:0] exp_rd;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_rd  = '0;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [63:0] addr, logic [1:0] size, bit sgn,
                                logic [63:0] wdata, logic [63:0] rdata, int k1, int k2,
                                bit e, logic [63:0] r);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.size = size; v.sgn = sgn;
        v.wdata = wdata; v.rdata = rdata; v.k1 = k1; v.k2 = k2;
        v.exp_err = e; v.exp_rd = r;
        return v;
    endfunction

    // Reference load extension: keep the low 8*2^size bits, fill above by sign or zero
    function automatic logic [63:0] ref_ext(logic [63:0] d, logic [1:0] size, bit sgn);
        int          bits;
        logic [63:0] mask;
        logic [63:0] low;
        bits = 8 << size;
        if (bits == 64) return d;
        mask = (64'd1 << bits) - 64'd1;
        low  = d & mask;
        if (sgn && d[bits-1]) low = low | ~mask;
        return low;
    endfunction

    task automatic clear_inputs();
        cpu_mem_read = 1'b0; cpu_mem_write = 1'b0; cpu_signed = 1'b0;
        cpu_address = '0; cpu_size = '0; cpu_write_data = '0;
        read_ready = 1'b0; write_ready = 1'b0; write_finished = 1'b0;
        mem_read_data = '0;
    endtask

    // Runs one transaction starting from IDLE; cycle 0 presents the request, DONE is cycle nwait+1
    task automatic run_txn(input vec_t t, output bit got_err, output logic [63:0] got_rd);
        bit fault, is_load, err;
        int nrd, nwr, ndone, nwait, done_c, start, idx;
        fault   = (t.rd && t.wr) || ((t.addr % (64'd1 << t.size)) != 0);
        is_load = t.rd && !t.wr;
        err = fault; nrd = 0; nwr = 0; ndone = 0; got_err = 0; got_rd = '0;
        if (!fault && is_load) begin
            if (t.k1 < T) nrd = t.k1 + 1;
            else begin nrd = T; err = 1; end
        end else if (!fault) begin
            if (t.k1 >= T) begin nwr = T; err = 1; end
            else begin
                nwr   = t.k1 + 1;
                start = (t.k1 + 1 < T - 1) ? t.k1 + 1 : T - 1;
                if (t.k2 < T - start) ndone = t.k2 + 1;
                else begin ndone = T - start; err = 1; end
            end
        end
        nwait  = nrd + nwr + ndone;
        done_c = nwait + 1;
        if (is_load && !err) exp_rd = ref_ext(t.rdata, t.size, t.sgn);

        for (int c = 0; c <= done_c; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cpu_mem_read = t.rd; cpu_mem_write = t.wr; cpu_address = t.addr;
                cpu_size = t.size; cpu_signed = t.sgn; cpu_write_data = t.wdata;
            end else if (c < done_c) begin
                cpu_mem_read = 1'($urandom); cpu_mem_write = 1'($urandom);
                cpu_address = {$urandom, $urandom}; cpu_size = 2'($urandom);
                cpu_signed = 1'($urandom); cpu_write_data = {$urandom, $urandom};
            end else begin
                cpu_mem_read = 1'b0; cpu_mem_write = 1'b0;
            end
            read_ready = 1'($urandom); write_ready = 1'($urandom);
            write_finished = 1'($urandom); mem_read_data = {$urandom, $urandom};
            if (c >= 1 && c <= nrd) begin
                idx = c - 1;
                read_ready = (idx == t.k1);
                if (read_ready) mem_read_data = t.rdata;
            end else if (c >= 1 && c <= nwr) begin
                idx = c - 1;
                write_ready = (idx == t.k1);
            end else if (c > nwr && c <= nwr + ndone) begin
                idx = c - 1 - nwr;
                write_finished = (idx == t.k2);
            end
            #1;
            chk($sformatf("read_request c%0d", c), 64'(read_request), 64'(is_load && c >= 1 && c <= nrd));
            chk($sformatf("write_request c%0d", c), 64'(write_request), 64'(c >= 1 && c <= nwr));
            chk($sformatf("cpu_stall c%0d", c), 64'(cpu_stall), 64'(c < done_c));
            chk($sformatf("cpu_error c%0d", c), 64'(cpu_error), 64'(c == done_c && err));
            if (!fault && (c == 1 || c == nwait)) begin
                chk($sformatf("mem_address c%0d", c), mem_address, t.addr);
                chk($sformatf("mem_block_size c%0d", c), 64'(mem_block_size), 64'(t.size));
                chk($sformatf("mem_write_data c%0d", c), mem_write_data, t.wdata);
            end
            if (c == done_c) begin
                chk("cpu_read_data done", cpu_read_data, exp_rd);
                got_err = cpu_error;
                got_rd  = cpu_read_data;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " read_request"}, 64'(read_request), 64'd0);
        chk({tag, " write_request"}, 64'(write_request), 64'd0);
        chk({tag, " cpu_error"}, 64'(cpu_error), 64'd0);
        chk({tag, " cpu_stall"}, 64'(cpu_stall), 64'd0);
        chk({tag, " cpu_read_data"}, cpu_read_data, 64'd0);
        chk({tag, " mem_address"}, mem_address, 64'd0);
        chk({tag, " mem_block_size"}, 64'(mem_block_size), 64'd0);
        chk({tag, " mem_write_data"}, mem_write_data, 64'd0);
    endtask

    // Reset during WR_WAIT_DONE and during RD_WAIT (with a simultaneous handshake)
    task automatic reset_sequences();
        @(negedge clk);
        cpu_mem_write = 1'b1; cpu_address = 64'h20; cpu_size = 2'b10; cpu_write_data = 64'h1234_5678;
        @(negedge clk);
        cpu_mem_write = 1'b0; write_ready = 1'b1; #1;
        chk("rstwr write_request", 64'(write_request), 64'd1);
        @(negedge clk);
        write_ready = 1'b0; reset = 1'b1; write_finished = 1'b1; #1;
        chk("rstwr wait_done write_request", 64'(write_request), 64'd0);
        chk("rstwr wait_done stall", 64'(cpu_stall), 64'd1);
        @(negedge clk);
        reset = 1'b0; #1;
        check_all_zero("rstwr");
        exp_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            write_finished = 1'b1; #1;
            chk($sformatf("rstwr late_finish cpu_error %0d", i), 64'(cpu_error), 64'd0);
            chk($sformatf("rstwr late_finish stall %0d", i), 64'(cpu_stall), 64'd0);
            chk($sformatf("rstwr late_finish write_request %0d", i), 64'(write_request), 64'd0);
        end
        @(negedge clk);
        write_finished = 1'b0; cpu_mem_read = 1'b1; cpu_address = 64'h40; cpu_size = 2'b11;
        @(negedge clk);
        cpu_mem_read = 1'b0; #1;
        chk("rstrd read_request", 64'(read_request), 64'd1);
        @(negedge clk);
        reset = 1'b1; read_ready = 1'b1; mem_read_data = 64'hABCD; cpu_mem_read = 1'b1;
        @(negedge clk);
        reset = 1'b0; read_ready = 1'b0; cpu_mem_read = 1'b0; #1;
        check_all_zero("rstrd");
    endtask

    initial begin
        bit          ge;
        logic [63:0] gr;
        vec_t        t;
        int          r;
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0; #1;
        check_all_zero("post_reset idle");

        vecs.push_back(mk(1, 0, 64'h10,  2'b00, 1, 64'h0, 64'h80,                  6,  0, 0, 64'hFFFF_FFFF_FFFF_FF80));
        vecs.push_back(mk(1, 0, 64'h11,  2'b00, 0, 64'h0, 64'h1234_5680,           0,  0, 0, 64'h80));
        vecs.push_back(mk(1, 0, 64'h2,   2'b01, 1, 64'h0, 64'h1234_8765,           2,  0, 0, 64'hFFFF_FFFF_FFFF_8765));
        vecs.push_back(mk(1, 0, 64'h4,   2'b10, 1, 64'h0, 64'h7FFF_FFFF,           1,  0, 0, 64'h7FFF_FFFF));
        vecs.push_back(mk(1, 0, 64'h8,   2'b10, 1, 64'h0, 64'hDEAD_BEEF_8000_0001, 3,  0, 0, 64'hFFFF_FFFF_8000_0001));
        vecs.push_back(mk(1, 0, 64'h8,   2'b10, 0, 64'h0, 64'hDEAD_BEEF_8000_0001, 3,  0, 0, 64'h8000_0001));
        vecs.push_back(mk(1, 0, 64'h18,  2'b11, 1, 64'h0, 64'h8123_4567_89AB_CDEF, 4,  0, 0, 64'h8123_4567_89AB_CDEF));
        vecs.push_back(mk(0, 1, 64'h20,  2'b10, 0, 64'hCAFE_F00D, 64'h0,           3,  4, 0, 64'h8123_4567_89AB_CDEF));
        vecs.push_back(mk(1, 0, 64'h3,   2'b01, 0, 64'h0, 64'h0,                   0,  0, 1, 64'h8123_4567_89AB_CDEF));
        vecs.push_back(mk(1, 1, 64'h40,  2'b00, 0, 64'h0, 64'h0,                   0,  0, 1, 64'h8123_4567_89AB_CDEF));
        vecs.push_back(mk(1, 0, 64'h4,   2'b11, 0, 64'h0, 64'h0,                   0,  0, 1, 64'h8123_4567_89AB_CDEF));
        vecs.push_back(mk(1, 0, 64'h100, 2'b11, 0, 64'h0, 64'h55,                 63,  0, 0, 64'h55));
        vecs.push_back(mk(1, 0, 64'h108, 2'b11, 0, 64'h0, 64'h66,                 64,  0, 1, 64'h55));
        vecs.push_back(mk(0, 1, 64'h30,  2'b11, 0, 64'h77, 64'h0,                 70,  0, 1, 64'h55));
        vecs.push_back(mk(0, 1, 64'h31,  2'b00, 0, 64'h88, 64'h0,                 10, 52, 0, 64'h55));
        vecs.push_back(mk(0, 1, 64'h32,  2'b01, 0, 64'h99, 64'h0,                 10, 53, 1, 64'h55));
        vecs.push_back(mk(1, 0, 64'h0,   2'b01, 0, 64'h0, 64'hFFFF,                0,  0, 0, 64'hFFFF));

        foreach (vecs[i]) begin
            run_txn(vecs[i], ge, gr);
            chk($sformatf("vec%0d cpu_error", i), 64'(ge), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d cpu_read_data", i), gr, vecs[i].exp_rd);
        end

        reset_sequences();

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom % 100);
            t.rd = (r < 55); t.wr = (r < 5) || (r >= 55);
            t.size = 2'($urandom);
            t.addr = {$urandom, $urandom};
            if ($urandom % 4 != 0) t.addr = (t.addr >> t.size) << t.size;
            t.sgn = 1'($urandom);
            t.wdata = {$urandom, $urandom};
            t.rdata = {$urandom, $urandom};
            t.k1 = ($urandom % 10 == 0) ? int'($urandom_range(55, 70)) : int'($urandom_range(0, 8));
            t.k2 = ($urandom % 10 == 0) ? int'($urandom_range(50, 66)) : int'($urandom_range(0, 8));
            t.exp_err = 0; t.exp_rd = '0;
            run_txn(t, ge, gr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
